dot_product_seq: RTL



---
 rtl/dot_product_seq_if.sv | 27 ++
 rtl/dot_product_seq.sv | 107 ++++++++++
 2 files changed

// File: rtl/dot_product_seq_if.sv
// Operand/result handshake bundle for dot_product_seq.
// The master side drives the operands and start, and it consumes the result.
interface dot_product_seq_if #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ACC_W = 16
);
    logic                    start;
    logic                    in_ready;
    logic [WIDTH*SIZE-1:0]   a;
    logic [WIDTH*SIZE-1:0]   b;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        result;
    logic                    overflow;
    logic                    busy;

    modport master (
        output start, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, busy
    );

    modport slave (
        input  start, a, b, out_ready,
        output in_ready, out_valid, result, overflow, busy
    );
endinterface

// File: rtl/dot_product_seq.sv
// Sequential dot product: one multiplier and one accumulator are shared over SIZE element pairs.
// Operands are accepted in IDLE, summed in RUN, and the result is held in DONE until it is taken.
module dot_product_seq #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ACC_W = 16
) (
    input logic              clk,
    input logic              rst,
    dot_product_seq_if.slave bus
);
    localparam int unsigned IDX_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned PROD_W = 2 * WIDTH;
    // Wide enough for the full product and the carry, so one test covers both overflow sources.
    localparam int unsigned SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q;
    logic [WIDTH*SIZE-1:0] a_q;
    logic [WIDTH*SIZE-1:0] b_q;
    logic [ACC_W-1:0]      acc_q;
    logic [IDX_W-1:0]      idx_q;
    logic [ACC_W-1:0]      result_q;
    logic                  overflow_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  busy_q;

    logic [WIDTH-1:0]      elem_a;
    logic [WIDTH-1:0]      elem_b;
    logic [PROD_W-1:0]     prod;
    logic [SUM_W-1:0]      sum;
    logic                  carry;
    logic                  last;

    always_comb begin
        elem_a = '0;
        elem_b = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                elem_a = a_q[WIDTH*i +: WIDTH];
                elem_b = b_q[WIDTH*i +: WIDTH];
            end
        end
        prod  = elem_a * elem_b;
        sum   = SUM_W'(acc_q) + SUM_W'(prod);
        carry = |sum[SUM_W-1:ACC_W];
        last  = (idx_q == IDX_W'(SIZE - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        overflow_q <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    acc_q      <= sum[ACC_W-1:0];
                    overflow_q <= overflow_q | carry;
                    if (last) begin
                        result_q    <= sum[ACC_W-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = busy_q;
endmodule
